// File: rtl/qpsk_mapper.sv
// qpsk_mapper
// Payload symbol source for the TX chain. Accepts bytes on a valid/ready
// stream and emits four Gray-coded QPSK symbols per byte, MSB pair first,
// as W-bit signed I/Q samples on a second valid/ready stream. The outputs
// feed the SOF header framer directly.
//
// Optional build macro QPSK_MAPPER_SCRAMBLER_EN: enables a DVB-S style
// energy-dispersal scrambler (PRBS 1+x^14+x^15) applied to each accepted
// byte before mapping. The PRBS is reseeded on reset and after every byte
// that carries in_last. Without the macro, bytes are mapped unmodified.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   byte available
//   in_data    in   payload byte
//   in_last    in   byte is the last of its packet
//   in_ready   out  byte accepted when in_valid & in_ready
//   out_valid  out  symbol available
//   out_i      out  in-phase sample (two's complement)
//   out_q      out  quadrature sample (two's complement)
//   out_last   out  high with the 4th symbol of an in_last byte
//   out_ready  in   symbol consumed when out_valid & out_ready

module qpsk_mapper #(
   parameter int W   = 12,
   parameter int AMP = 1447
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   input  logic         in_last,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_i,
   output logic [W-1:0] out_q,
   output logic         out_last,
   input  logic         out_ready
);

   localparam logic [W-1:0] POS = W'(AMP);
   localparam logic [W-1:0] NEG = W'(-AMP);

   logic [7:0] sh;
   logic [1:0] sym_cnt;
   logic       loaded;
   logic       last_flag;

   logic       adv;
   logic       last_sym;
   logic       accept;
   logic [7:0] data_mapped;

   // The output register takes a new symbol whenever it is empty or its
   // current symbol is being consumed this cycle.
   assign adv      = loaded & (~out_valid | out_ready);
   assign last_sym = (sym_cnt == 2'd3);

   // Holder refills in the same cycle its 4th symbol moves to the output,
   // giving an uninterrupted one-symbol-per-clock stream.
   assign in_ready = ~loaded | (adv & last_sym);
   assign accept   = in_valid & in_ready;

`ifdef QPSK_MAPPER_SCRAMBLER_EN
   // lfsr[k] holds register stage rk; r1 receives the feedback bit.
   localparam logic [15:1] SEED = 15'b000000010101001;

   logic [15:1] lfsr;
   logic [15:1] lfsr_next;
   logic [7:0]  prbs;
   logic        prbs_bit;

   // Eight register shifts per byte; the first generated bit lands in the
   // byte MSB.
   always_comb begin
      lfsr_next = lfsr;
      prbs      = '0;
      prbs_bit  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         prbs_bit  = lfsr_next[14] ^ lfsr_next[15];
         prbs      = {prbs[6:0], prbs_bit};
         lfsr_next = {lfsr_next[14:1], prbs_bit};
      end
   end

   assign data_mapped = in_data ^ prbs;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr <= SEED;
      end else if (accept) begin
         lfsr <= in_last ? SEED : lfsr_next;
      end
   end
`else
   assign data_mapped = in_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sh        <= '0;
         sym_cnt   <= '0;
         loaded    <= 1'b0;
         last_flag <= 1'b0;
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
         out_last  <= 1'b0;
      end else begin
         if (adv) begin
            out_valid <= 1'b1;
            out_i     <= sh[7] ? NEG : POS;
            out_q     <= sh[6] ? NEG : POS;
            out_last  <= last_flag & last_sym;
            sh        <= {sh[5:0], 2'b00};
            sym_cnt   <= sym_cnt + 2'd1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // A new byte overrides the shift/count update of the symbol that
         // just left the holder.
         if (accept) begin
            sh        <= data_mapped;
            sym_cnt   <= '0;
            loaded    <= 1'b1;
            last_flag <= in_last;
         end else if (adv && last_sym) begin
            loaded    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qpsk_mapper.sv
module tb_qpsk_mapper;

   localparam int W   = 12;
   localparam int AMP = 1447;
   localparam int NBYTES = 512;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_last = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_i;
   logic [W-1:0] out_q;
   logic         out_last;
   logic         out_ready = 1'b0;

   qpsk_mapper #(.W(W), .AMP(AMP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_i     (out_i),
      .out_q     (out_q),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int i; int q; bit last; } sym_t;
   typedef struct { logic [W-1:0] i; logic [W-1:0] q; logic last; } raw_t;

   sym_t exp_q[$];
   raw_t got_q[$];
   bit   prbs_seq[8*NBYTES];
   int   prbs_k = 0;
   int   n_pop  = 0;
   int   n_stall = 0;

   bit           stall_prev = 0;
   logic [W-1:0] prev_i, prev_q;
   logic         prev_last;

   // PRBS as a bit sequence: s[m] = s[m-15] ^ s[m-14]; the first 15 entries
   // are the seed stages r15..r1, generated bits follow.
   task automatic build_prbs();
      int r[16];
      int s[8*NBYTES + 15];
      r = '{0, 1,0,0,1,0,1,0,1,0,0,0,0,0,0,0};
      for (int k = 0; k < 15; k++) s[k] = r[15 - k];
      for (int m = 15; m < 8*NBYTES + 15; m++) s[m] = s[m-15] ^ s[m-14];
      for (int n = 0; n < 8*NBYTES; n++) prbs_seq[n] = bit'(s[n + 15]);
   endtask

   function automatic int scramble(input int d);
      int v = d;
`ifdef QPSK_MAPPER_SCRAMBLER_EN
      for (int b = 0; b < 8; b++)
         if (prbs_seq[prbs_k*8 + b]) v = v ^ (1 << (7 - b));
`endif
      return v;
   endfunction

   task automatic model_accept(input int d, input bit last);
      int   sb = scramble(d);
      int   pair;
      sym_t e;
      for (int k = 0; k < 4; k++) begin
         pair   = (sb >> (6 - 2*k)) % 4;
         e.i    = (pair >= 2)    ? -AMP : AMP;
         e.q    = (pair % 2 == 1) ? -AMP : AMP;
         e.last = last && (k == 3);
         exp_q.push_back(e);
      end
`ifdef QPSK_MAPPER_SCRAMBLER_EN
      prbs_k = last ? 0 : prbs_k + 1;
`endif
   endtask

   // One clock: drive at the falling edge, sample 1 time unit before the
   // rising edge, then predict what that rising edge transfers.
   task automatic step(input bit v, input logic [7:0] d, input bit l,
                       input bit r, output bit acc);
      sym_t e;
      raw_t g;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      out_ready = r;
      #4;
      if (stall_prev) begin
         n_stall++;
         chk("stall_valid", int'(out_valid), 1);
         chk("stall_i", int'(out_i), int'(prev_i));
         chk("stall_q", int'(out_q), int'(prev_q));
         chk("stall_last", int'(out_last), int'(prev_last));
      end
      if (out_valid && out_ready) begin
         g.i = out_i; g.q = out_q; g.last = out_last;
         got_q.push_back(g);
         n_pop++;
         if (exp_q.size() == 0) begin
            chk("unexpected_symbol_queue", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk("sym_i", int'($signed(out_i)), e.i);
            chk("sym_q", int'($signed(out_q)), e.q);
            chk("sym_last", int'(out_last), int'(e.last));
         end
      end
      stall_prev = out_valid && !out_ready;
      prev_i = out_i; prev_q = out_q; prev_last = out_last;
      acc = in_valid && in_ready;
      if (acc) model_accept(int'(in_data), in_last);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      got_q.delete();
      prbs_k = 0;
      stall_prev = 0;
   endtask

   task automatic drain();
      bit acc;
      int c = 0;
      while ((exp_q.size() != 0 || out_valid) && c < 60) begin
         step(0, 8'h00, 0, 1, acc);
         c++;
      end
      chk("drain_left", exp_q.size(), 0);
      chk("drain_idle", int'(out_valid), 0);
   endtask

   task automatic send(input logic [7:0] d, input bit l);
      bit acc = 0;
      for (int n = 0; n < 20 && !acc; n++) step(1, d, l, 1, acc);
      chk("send_accept", int'(acc), 1);
   endtask

   typedef struct { logic [7:0] d; bit last; logic [1:0] p[4]; } vec_t;
   vec_t tbl[4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit acc;
      int cyc, nsent, vcount, first, lastc;
      int acc_cyc[8];
      bit sent;
      logic [11:0] ei, eq;

`ifdef QPSK_MAPPER_SCRAMBLER_EN
      tbl[0] = '{8'h00, 1'b0, '{2'd0, 2'd0, 2'd0, 2'd3}};
      tbl[1] = '{8'h00, 1'b1, '{2'd3, 2'd3, 2'd1, 2'd2}};
      tbl[2] = '{8'h00, 1'b0, '{2'd0, 2'd0, 2'd0, 2'd3}};
      tbl[3] = '{8'h1B, 1'b0, '{2'd3, 2'd2, 2'd3, 2'd1}};
`else
      tbl[0] = '{8'h1B, 1'b0, '{2'd0, 2'd1, 2'd2, 2'd3}};
      tbl[1] = '{8'hE4, 1'b1, '{2'd3, 2'd2, 2'd1, 2'd0}};
      tbl[2] = '{8'h00, 1'b0, '{2'd0, 2'd0, 2'd0, 2'd0}};
      tbl[3] = '{8'hFF, 1'b1, '{2'd3, 2'd3, 2'd3, 2'd3}};
`endif
      build_prbs();

      // reset state
      do_reset();
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_i", int'(out_i), 0);
      chk("rst_out_q", int'(out_q), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      // table: single bytes against literal symbol values
      for (int e = 0; e < 4; e++) begin
         got_q.delete();
         send(tbl[e].d, tbl[e].last);
         drain();
         chk("tbl_count", got_q.size(), 4);
         for (int k = 0; k < 4 && k < got_q.size(); k++) begin
            ei = tbl[e].p[k][1] ? 12'hA59 : 12'h5A7;
            eq = tbl[e].p[k][0] ? 12'hA59 : 12'h5A7;
            chk("tbl_i", int'(got_q[k].i), int'(ei));
            chk("tbl_q", int'(got_q[k].q), int'(eq));
            chk("tbl_last", int'(got_q[k].last), int'(tbl[e].last && k == 3));
         end
      end

      // latency: accept at edge N, symbol visible only after edge N+1
      do_reset();
      step(1, 8'h5A, 0, 1, acc);
      chk("lat_accept", int'(acc), 1);
      step(0, 8'h00, 0, 1, acc);
      chk("lat_edge_n", int'(out_valid), 0);
      step(0, 8'h00, 0, 1, acc);
      chk("lat_edge_n1", int'(out_valid), 1);
      drain();

      // 8 bytes back-to-back
      cyc = 0; nsent = 0; vcount = 0; first = -1; lastc = 0;
      while ((nsent < 8 || exp_q.size() != 0) && cyc < 80) begin
         step(nsent < 8, 8'(nsent*37 + 5), 0, 1, acc);
         if (out_valid) begin
            vcount++;
            if (first < 0) first = cyc;
            lastc = cyc;
         end
         if (acc) begin
            acc_cyc[nsent] = cyc;
            nsent++;
         end
         cyc++;
      end
      chk("b2b_sent", nsent, 8);
      chk("b2b_valid_cycles", vcount, 32);
      chk("b2b_contiguous", lastc - first + 1, 32);
      for (int k = 1; k < 8 && k < nsent; k++)
         chk("b2b_in_ready_period", acc_cyc[k] - acc_cyc[k-1], 4);
      drain();

      // backpressure: out_ready pattern 1,0,0,1,...
      cyc = 0; sent = 0; n_stall = 0;
      while ((!sent || exp_q.size() != 0) && cyc < 60) begin
         step(!sent, 8'h1B, 0, (cyc % 4 == 0) || (cyc % 4 == 3), acc);
         if (acc) sent = 1;
         cyc++;
      end
      chk("bp_sent", int'(sent), 1);
      chk("bp_stalls_seen", int'(n_stall > 0), 1);
      drain();

      // reset after the 2nd symbol of a byte
      do_reset();
      send(8'h1B, 0);
      n_pop = 0;
      for (int c = 0; c < 20 && n_pop < 2; c++) step(0, 8'h00, 0, 1, acc);
      chk("mid_pops", n_pop, 2);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete(); got_q.delete(); prbs_k = 0; stall_prev = 0;
      #4;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_in_ready", int'(in_ready), 1);
      send(8'hE4, 0);
      drain();
      chk("mid_next_count", got_q.size(), 4);

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 9) < 7, 8'($urandom),
              ($urandom_range(0, 7) == 0) || (prbs_k >= NBYTES - 100),
              $urandom_range(0, 9) < 6, acc);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
